// File: rtl/system_bus_arbiter.sv
// rtl/system_bus_arbiter.sv - two-master, single-slave bus arbiter with waitrequest timeout
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise master 0 wins every tie.
module system_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  input  logic [31:0] readData,
  input  logic        waitrequest,
  output logic        err_timeout
);

  // Counter is wide enough to reach TIMEOUT_CYCLES and never narrower than one bit.
  localparam int unsigned     CntW       = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
  localparam bit              TimeoutEn  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic [31:0]     addrQ;
  logic [31:0]     wdataQ;
  logic [3:0]      wstrbQ;
  logic            grantQ;
  logic [CntW-1:0] waitCnt;
  logic [CntW-1:0] waitCntInc;
  logic [31:0]     rdata0Q;
  logic [31:0]     rdata1Q;
  logic            errQ;

  logic anyValid;
  logic winner;
  logic isRead;
  logic hitTimeout;

  assign anyValid   = m0_valid | m1_valid;
  assign isRead     = (wstrbQ == 4'h0);
  assign waitCntInc = waitCnt + CntW'(1);
  // A low waitrequest always wins over the abort, so the limit only matters while stalled.
  assign hitTimeout = TimeoutEn && waitrequest && (waitCntInc == TimeoutVal);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic lastGrant;

  assign winner = (m0_valid && m1_valid) ? ~lastGrant : m1_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lastGrant <= 1'b1;
    end else if (state == RESP) begin
      lastGrant <= grantQ;
    end
  end
`else
  assign winner = m1_valid & ~m0_valid;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    read      = 1'b0;
    write     = 1'b0;
    case (state)
      IDLE: begin
        if (anyValid) begin
          stateNext = BUS;
        end
      end
      BUS: begin
        read  = isRead;
        write = ~isRead;
        if (!waitrequest || hitTimeout) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addrQ   <= '0;
      wdataQ  <= '0;
      wstrbQ  <= '0;
      grantQ  <= 1'b0;
      waitCnt <= '0;
      rdata0Q <= '0;
      rdata1Q <= '0;
      errQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            grantQ  <= winner;
            addrQ   <= winner ? m1_addr  : m0_addr;
            wdataQ  <= winner ? m1_wdata : m0_wdata;
            wstrbQ  <= winner ? m1_wstrb : m0_wstrb;
            waitCnt <= '0;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            // Writes keep the previous read data visible to the master.
            if (isRead) begin
              if (grantQ) begin
                rdata1Q <= readData;
              end else begin
                rdata0Q <= readData;
              end
            end
          end else if (hitTimeout) begin
            if (grantQ) begin
              rdata1Q <= 32'hFFFF_FFFF;
            end else begin
              rdata0Q <= 32'hFFFF_FFFF;
            end
            errQ <= 1'b1;
          end else begin
            waitCnt <= waitCntInc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m0_ready    = (state == RESP) && !grantQ;
  assign m1_ready    = (state == RESP) &&  grantQ;
  assign m0_rdata    = rdata0Q;
  assign m1_rdata    = rdata1Q;
  assign address     = addrQ;
  assign writeData   = wdataQ;
  assign byteenable  = wstrbQ;
  assign err_timeout = errQ;

endmodule

// File: doc/system_bus_arbiter.md
SYSTEM_BUS_ARBITER -- requirements
Module: system_bus_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max BUS-state cycles with waitrequest high before abort; 0 disables timeout.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have, for each master N in {0,1}, ports:
- mN_valid  in  1  request.
- mN_ready  out  1  one-cycle completion pulse.
- mN_addr  in  32  byte address.
- mN_wdata  in  32  write data.
- mN_wstrb  in  4  byte strobes; 0 means read.
- mN_rdata  out  32  read data.
REQ-004 SHALL have slave-side ports:
- address  out  32  latched address.
- writeData  out  32  latched write data.
- byteenable  out  4  latched strobes.
- read  out  1  read command.
- write  out  1  write command.
- readData  in  32  OR-combined slave read data.
- waitrequest  in  1  slave stall.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement FSM states IDLE, BUS, RESP.
REQ-006 In IDLE with any mN_valid high, SHALL select a winner (REQ-013), latch its addr/wdata/wstrb and master index, clear the timeout counter, and enter BUS next cycle.
REQ-007 In IDLE with no valid, SHALL stay in IDLE.
REQ-008 In BUS, read SHALL be 1 iff latched wstrb==0, write SHALL be 1 iff latched wstrb!=0; both SHALL be 0 in IDLE and RESP.
REQ-009 In BUS, a cycle with waitrequest==0 SHALL complete the transfer: capture readData (reads only; writes leave rdata unchanged) and enter RESP.
REQ-010 In BUS with waitrequest==1, the counter SHALL increment; when it equals TIMEOUT_CYCLES (nonzero), the FSM SHALL abort: rdata=32'hFFFF_FFFF, err_timeout set, enter RESP.
REQ-011 If waitrequest==0 in the same cycle the counter reaches its limit, normal completion SHALL take precedence; err_timeout SHALL NOT be set.
REQ-012 In RESP, mN_ready SHALL be 1 for exactly one cycle for the latched master only; mN_rdata SHALL hold the captured value; the FSM SHALL then return to IDLE.
REQ-013 Arbitration SHALL be per REQ-020/021; a single requester SHALL always win.
REQ-014 Master inputs SHALL be ignored outside IDLE; a valid dropped mid-transfer SHALL NOT abort it, and ready SHALL still pulse.
REQ-015 Minimum latency SHALL be 3 cycles from valid sampled in IDLE to the ready pulse (IDLE, BUS, RESP); each waitrequest cycle SHALL add 1.
REQ-016 address/writeData/byteenable SHALL be driven from the latch registers in all states.

Reset
REQ-017 On a rising clk with resetn==0, SHALL set: FSM=IDLE; read=write=0; m0_ready=m1_ready=0; m0_rdata=m1_rdata=0; address/writeData/byteenable=0; counter=0; err_timeout=0; last-grant=master 1 (so master 0 wins the first tie).
REQ-018 Reset mid-transfer SHALL abandon the transfer with no ready pulse; read/write SHALL be 0 in the cycle after the reset edge.
REQ-019 err_timeout SHALL be cleared only by reset.

Configuration
REQ-020 With BUS_ARB_ROUND_ROBIN_EN defined, on a tie the master not granted last SHALL win, and last-grant SHALL update on each RESP.
REQ-021 Without BUS_ARB_ROUND_ROBIN_EN, master 0 SHALL always win ties, and the last-grant register SHALL be omitted.

Verification
REQ-022 Read: m0 valid, addr 0x1000_0010, wstrb 0; slave waitrequest 0, readData 0xCAFE_0001 -> read high for 1 cycle, m0_ready pulses 3 cycles after valid, m0_rdata = 0xCAFE_0001.
REQ-023 Write with stall: m1 valid, addr 0x2010_0000, wdata 0x55, wstrb 0xF; waitrequest high for 4 cycles -> write high for 5 cycles, m1_ready at cycle 7, m0_ready stays 0.
REQ-024 Tie: both masters hold valid for 3 back-to-back transfers -> with macro, grants m0, m1, m0; without macro, grants m0, m0, m0.
REQ-025 Timeout: TIMEOUT_CYCLES=8, waitrequest stuck high -> abort after 8 BUS cycles, m0_rdata = 0xFFFF_FFFF, err_timeout = 1 until reset; variant with waitrequest low on cycle 8 -> normal completion, err_timeout = 0.
REQ-026 Reset in BUS: resetn low for 1 cycle during a stalled read -> no ready pulse, read = 0 next cycle, all outputs at REQ-017 values, next request served normally.
